// File: rtl/controle_jogo.sv
// controle_jogo -- game-flow controller for the player ship.
// Sequences the start, play, pause, explosion, respawn-invulnerability and
// game-over phases. It also generates the frame-rate movement strobe, the
// ship blink and the life counter.
//
// Ports:
//   CLOCK_50      in   system clock
//   reset         in   synchronous, active-high reset
//   btn_start     in   start/restart key (synchronized level)
//   btn_pausa     in   pause key (synchronized level)
//   colisao       in   ship hit (level, sampled every cycle)
//   pausa         out  1 = ship/shots/enemies hold position
//   reiniciarJogo out  one-cycle pulse that re-places the ship
//   move_tick     out  one-cycle movement strobe per frame
//   nave_visivel  out  ship sprite draw enable
//   invulneravel  out  high while in INVULN
//   vidas         out  remaining lives
//   game_over     out  high in FIM
//   estado        out  current state code
module controle_jogo #(
  parameter int TICK_DIV       = 833333,
  parameter int VIDAS_INICIAIS = 3,
  parameter int EXPLOSAO_TICKS = 60,
  parameter int INVULN_TICKS   = 120,
  parameter int PISCA_TICKS    = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pausa,
  input  logic       colisao,
  output logic       pausa,
  output logic       reiniciarJogo,
  output logic       move_tick,
  output logic       nave_visivel,
  output logic       invulneravel,
  output logic [1:0] vidas,
  output logic       game_over,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    ESPERA     = 3'd0,
    JOGANDO    = 3'd1,
    PAUSADO    = 3'd2,
    EXPLODINDO = 3'd3,
    INVULN     = 3'd4,
    FIM        = 3'd5
  } estado_t;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int T_MAX = (EXPLOSAO_TICKS > INVULN_TICKS) ? EXPLOSAO_TICKS : INVULN_TICKS;
  localparam int TMR_W = $clog2(T_MAX + 1);
  localparam int PSC_W = (PISCA_TICKS > 1) ? $clog2(PISCA_TICKS) : 1;

  localparam logic [DIV_W-1:0] DIV_FIM   = DIV_W'(TICK_DIV - 1);
  localparam logic [TMR_W-1:0] EXP_FIM   = TMR_W'(EXPLOSAO_TICKS - 1);
  localparam logic [TMR_W-1:0] INV_FIM   = TMR_W'(INVULN_TICKS - 1);
  localparam logic [PSC_W-1:0] PSC_FIM   = PSC_W'(PISCA_TICKS - 1);
  localparam logic [1:0]       VIDAS_INI = 2'(VIDAS_INICIAIS);

  // Registers
  logic             r_prev_start, r_prev_pausa;
  logic [DIV_W-1:0] r_div;
  logic [TMR_W-1:0] r_timer;
  logic [PSC_W-1:0] r_pisca;
  estado_t          r_estado, r_retorno;
  logic [1:0]       r_vidas;
  logic             r_pausa, r_reinicia, r_move, r_visivel, r_invuln, r_fim;

  // Combinational signals
  logic             w_start_edge, w_pausa_edge, w_frame_tick, w_limpa_timer;
  estado_t          w_prox, w_retorno_prox;
  logic [1:0]       w_vidas_prox;
  logic             w_reinicia_prox, w_pausa_prox, w_visivel_prox;
  logic             w_invuln_prox, w_fim_prox;
  logic [PSC_W-1:0] w_pisca_prox;

  assign w_start_edge = btn_start & ~r_prev_start;
  assign w_pausa_edge = btn_pausa & ~r_prev_pausa;
  assign w_frame_tick = (r_div == DIV_FIM);

  // Timer restarts on a real phase change; moving into or out of PAUSADO
  // leaves it alone so a paused INVULN resumes where it stopped.
  assign w_limpa_timer = (w_prox != r_estado) && (w_prox != PAUSADO) && (r_estado != PAUSADO);

  // Button history and free-running frame divider.
  // Previous-key registers reset to 1 so a key held through reset is not an edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_prev_start <= 1'b1;
      r_prev_pausa <= 1'b1;
      r_div        <= '0;
    end else begin
      r_prev_start <= btn_start;
      r_prev_pausa <= btn_pausa;
      r_div        <= w_frame_tick ? '0 : r_div + 1'b1;
    end
  end

  // Phase timer: counts frame ticks only in the timed phases.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_limpa_timer) begin
      r_timer <= '0;
    end else if (w_frame_tick && (r_estado == EXPLODINDO || r_estado == INVULN)) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= r_timer;
    end
  end

  // Next-state logic, return-state bookkeeping and life counter.
  always_comb begin
    w_prox          = r_estado;
    w_retorno_prox  = r_retorno;
    w_vidas_prox    = r_vidas;
    w_reinicia_prox = 1'b0;
    case (r_estado)
      ESPERA: begin
        if (w_start_edge) begin
          w_prox          = JOGANDO;
          w_vidas_prox    = VIDAS_INI;
          w_reinicia_prox = 1'b1;
        end else begin
          w_prox = ESPERA;
        end
      end
      JOGANDO: begin
        // colisao has priority over a simultaneous pause edge
        if (colisao) begin
          w_prox       = EXPLODINDO;
          w_vidas_prox = (r_vidas != 2'd0) ? r_vidas - 2'd1 : 2'd0;
        end else if (w_pausa_edge) begin
          w_prox         = PAUSADO;
          w_retorno_prox = JOGANDO;
        end else begin
          w_prox = JOGANDO;
        end
      end
      PAUSADO: begin
        if (w_pausa_edge) begin
          w_prox = r_retorno;
        end else begin
          w_prox = PAUSADO;
        end
      end
      EXPLODINDO: begin
        if (w_frame_tick && r_timer == EXP_FIM) begin
          if (r_vidas == 2'd0) begin
            w_prox = FIM;
          end else begin
            w_prox          = INVULN;
            w_reinicia_prox = 1'b1;
          end
        end else begin
          w_prox = EXPLODINDO;
        end
      end
      INVULN: begin
        if (w_frame_tick && r_timer == INV_FIM) begin
          w_prox = JOGANDO;
        end else if (w_pausa_edge) begin
          w_prox         = PAUSADO;
          w_retorno_prox = INVULN;
        end else begin
          w_prox = INVULN;
        end
      end
      FIM: begin
        if (w_start_edge) begin
          w_prox          = JOGANDO;
          w_vidas_prox    = VIDAS_INI;
          w_reinicia_prox = 1'b1;
        end else begin
          w_prox = FIM;
        end
      end
      default: begin
        w_prox       = ESPERA;
        w_vidas_prox = VIDAS_INI;
      end
    endcase
  end

  // Registered outputs derived from the next state; PAUSADO holds them.
  always_comb begin
    w_pausa_prox   = 1'b1;
    w_visivel_prox = r_visivel;
    w_invuln_prox  = r_invuln;
    w_fim_prox     = r_fim;
    w_pisca_prox   = r_pisca;
    // Blink advances on frame ticks spent in INVULN
    if (r_estado == INVULN && w_frame_tick) begin
      if (r_pisca == PSC_FIM) begin
        w_visivel_prox = ~r_visivel;
        w_pisca_prox   = '0;
      end else begin
        w_pisca_prox = r_pisca + 1'b1;
      end
    end else begin
      w_pisca_prox = r_pisca;
    end
    case (w_prox)
      ESPERA, JOGANDO: begin
        w_pausa_prox   = (w_prox == ESPERA);
        w_visivel_prox = 1'b1;
        w_invuln_prox  = 1'b0;
        w_fim_prox     = 1'b0;
        w_pisca_prox   = '0;
      end
      PAUSADO: begin
        w_pausa_prox = 1'b1;
      end
      EXPLODINDO, FIM: begin
        w_pausa_prox   = 1'b1;
        w_visivel_prox = 1'b0;
        w_invuln_prox  = 1'b0;
        w_fim_prox     = (w_prox == FIM);
        w_pisca_prox   = '0;
      end
      INVULN: begin
        w_pausa_prox  = 1'b0;
        w_invuln_prox = 1'b1;
        w_fim_prox    = 1'b0;
        // fresh respawn starts visible; resume from pause keeps blink phase
        if (r_estado == EXPLODINDO) begin
          w_visivel_prox = 1'b1;
          w_pisca_prox   = '0;
        end else begin
          w_visivel_prox = w_visivel_prox;
        end
      end
      default: begin
        w_pausa_prox   = 1'b1;
        w_visivel_prox = 1'b1;
        w_invuln_prox  = 1'b0;
        w_fim_prox     = 1'b0;
        w_pisca_prox   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_estado   <= ESPERA;
      r_retorno  <= JOGANDO;
      r_vidas    <= VIDAS_INI;
      r_pausa    <= 1'b1;
      r_reinicia <= 1'b0;
      r_move     <= 1'b0;
      r_visivel  <= 1'b1;
      r_invuln   <= 1'b0;
      r_fim      <= 1'b0;
      r_pisca    <= '0;
    end else begin
      r_estado   <= w_prox;
      r_retorno  <= w_retorno_prox;
      r_vidas    <= w_vidas_prox;
      r_pausa    <= w_pausa_prox;
      r_reinicia <= w_reinicia_prox;
      r_move     <= w_frame_tick & (r_estado == JOGANDO || r_estado == INVULN);
      r_visivel  <= w_visivel_prox;
      r_invuln   <= w_invuln_prox;
      r_fim      <= w_fim_prox;
      r_pisca    <= w_pisca_prox;
    end
  end

  assign pausa         = r_pausa;
  assign reiniciarJogo = r_reinicia;
  assign move_tick     = r_move;
  assign nave_visivel  = r_visivel;
  assign invulneravel  = r_invuln;
  assign vidas         = r_vidas;
  assign game_over     = r_fim;
  assign estado        = r_estado;

endmodule

// File: tb/tb_controle_jogo.sv
// Self-checking bench for controle_jogo with small timing parameters.
module tb_controle_jogo;

  logic       clk = 1'b0;
  logic       reset, btn_start, btn_pausa, colisao;
  logic       pausa, reiniciarJogo, move_tick, nave_visivel, invulneravel, game_over;
  logic [1:0] vidas;
  logic [2:0] estado;

  int n_total = 0;
  int n_pass  = 0;

  controle_jogo #(
    .TICK_DIV(4), .VIDAS_INICIAIS(3), .EXPLOSAO_TICKS(3),
    .INVULN_TICKS(4), .PISCA_TICKS(2)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .btn_start(btn_start), .btn_pausa(btn_pausa),
    .colisao(colisao), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
    .move_tick(move_tick), .nave_visivel(nave_visivel), .invulneravel(invulneravel),
    .vidas(vidas), .game_over(game_over), .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic checar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_total++;
    if (obs === esp) n_pass++;
    else $display("FAIL %s: obtido %0d esperado %0d", tag, obs, esp);
  endtask

  // one clock; inputs change and outputs are sampled on the falling edge
  task automatic ciclo;
    @(negedge clk);
  endtask

  task automatic pulsa_start;
    btn_start = 1'b1; ciclo; btn_start = 1'b0;
  endtask

  task automatic pulsa_pausa;
    btn_pausa = 1'b1; ciclo; btn_pausa = 1'b0;
  endtask

  task automatic espera_estado(input logic [2:0] alvo, input int limite, input string tag);
    int n = 0;
    while (estado !== alvo && n < limite) begin ciclo; n++; end
    checar(tag, estado, alvo);
  endtask

  task automatic checa_reset(input string pre);
    checar({pre, "_estado"}, estado, 0);
    checar({pre, "_pausa"}, pausa, 1);
    checar({pre, "_reinicia"}, reiniciarJogo, 0);
    checar({pre, "_move"}, move_tick, 0);
    checar({pre, "_visivel"}, nave_visivel, 1);
    checar({pre, "_invuln"}, invulneravel, 0);
    checar({pre, "_vidas"}, vidas, 3);
    checar({pre, "_game_over"}, game_over, 0);
  endtask

  initial begin
    int mt, d;
    logic [3:0] vis_bits;
    reset = 1'b1; btn_start = 1'b0; btn_pausa = 1'b0; colisao = 1'b0;
    ciclo; ciclo;
    reset = 1'b0;
    checa_reset("rst");

    // idle in ESPERA: no movement strobes
    mt = 0;
    for (int i = 0; i < 20; i++) begin ciclo; mt += int'(move_tick); end
    checar("espera_move", mt, 0);
    checar("espera_estado", estado, 0);
    checar("espera_pausa", pausa, 1);
    checar("espera_vidas", vidas, 3);

    // start
    pulsa_start;
    checar("start_reinicia", reiniciarJogo, 1);
    checar("start_estado", estado, 1);
    checar("start_pausa", pausa, 0);
    ciclo;
    checar("start_reinicia_fim", reiniciarJogo, 0);
    mt = 0;
    for (int i = 0; i < 16; i++) begin mt += int'(move_tick); ciclo; end
    checar("jogando_move", mt, 4);

    // pause and resume
    pulsa_pausa;
    checar("pausa_estado", estado, 2);
    checar("pausa_pausa", pausa, 1);
    ciclo;
    mt = 0;
    for (int i = 0; i < 12; i++) begin ciclo; mt += int'(move_tick); end
    checar("pausa_move", mt, 0);
    pulsa_pausa;
    checar("retoma_estado", estado, 1);
    checar("retoma_pausa", pausa, 0);
    mt = 0;
    for (int i = 0; i < 16; i++) begin ciclo; mt += int'(move_tick); end
    checar("retoma_move", mt, 4);
    checar("retoma_vidas", vidas, 3);

    // first collision, pause during explosion ignored
    colisao = 1'b1; ciclo; colisao = 1'b0;
    checar("col1_estado", estado, 3);
    checar("col1_vidas", vidas, 2);
    checar("col1_visivel", nave_visivel, 0);
    checar("col1_pausa", pausa, 1);
    pulsa_pausa;
    checar("explosao_pausa_ignorada", estado, 3);
    d = 1;
    while (reiniciarJogo !== 1'b1 && d < 40) begin ciclo; d++; end
    checar("dur_explosao_9a12", (d >= 9 && d <= 12), 1);
    checar("respawn_reinicia", reiniciarJogo, 1);
    checar("respawn_estado", estado, 4);
    checar("respawn_invuln", invulneravel, 1);
    checar("respawn_pausa", pausa, 0);

    // INVULN: 16 cycles, blink 1,1,0,0 per frame tick, colisao ignored
    mt = 0; vis_bits = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) vis_bits[i/4] = nave_visivel;
      mt += int'(move_tick);
      if (i == 13) checar("invuln_colisao_ignorada", estado, 4);
      if (i == 1) colisao = 1'b1;
      if (i == 13) colisao = 1'b0;
      ciclo;
    end
    checar("invuln_pisca", vis_bits, 4'b0011);
    checar("invuln_move", mt, 3);
    checar("invuln_fim_estado", estado, 1);
    checar("invuln_fim_visivel", nave_visivel, 1);
    checar("invuln_fim_invuln", invulneravel, 0);
    checar("invuln_fim_vidas", vidas, 2);

    // collision and pause edge together: collision wins
    ciclo; ciclo;
    colisao = 1'b1; btn_pausa = 1'b1; ciclo; colisao = 1'b0; btn_pausa = 1'b0;
    checar("col2_prioridade", estado, 3);
    checar("col2_vidas", vidas, 1);
    espera_estado(3'd4, 40, "col2_respawn");
    espera_estado(3'd1, 40, "col2_volta");

    // last life
    ciclo;
    colisao = 1'b1; ciclo; colisao = 1'b0;
    checar("col3_estado", estado, 3);
    checar("col3_vidas", vidas, 0);
    espera_estado(3'd5, 40, "fim_estado");
    checar("fim_game_over", game_over, 1);
    checar("fim_vidas", vidas, 0);
    checar("fim_visivel", nave_visivel, 0);
    checar("fim_pausa", pausa, 1);
    checar("fim_reinicia", reiniciarJogo, 0);
    repeat (5) ciclo;
    checar("fim_permanece", estado, 5);
    pulsa_start;
    checar("restart_estado", estado, 1);
    checar("restart_vidas", vidas, 3);
    checar("restart_reinicia", reiniciarJogo, 1);
    checar("restart_game_over", game_over, 0);

    // reset during INVULN
    ciclo;
    colisao = 1'b1; ciclo; colisao = 1'b0;
    espera_estado(3'd4, 40, "pre_reset_invuln");
    ciclo; ciclo; ciclo;
    reset = 1'b1; ciclo; reset = 1'b0;
    checa_reset("rst_invuln");

    // start key held through reset release
    btn_start = 1'b1; reset = 1'b1; ciclo; ciclo; reset = 1'b0;
    repeat (10) ciclo;
    checar("start_preso_estado", estado, 0);
    btn_start = 1'b0; ciclo; ciclo;
    checar("start_solto_estado", estado, 0);
    pulsa_start;
    checar("start_novo_estado", estado, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
